// File: rtl/lfsr_keystream_cipher_if.sv
// Stream bundle for the keystream cipher: one valid/ready input and one valid/ready output.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready flow through the modports unchanged.
interface lfsr_keystream_cipher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Source/sink side: drives input words and accepts output words.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Cipher side: consumes input words and presents output words.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/lfsr_keystream_cipher.sv
// Fibonacci-LFSR stream cipher: XORs DATA_W keystream bits into each accepted word.
// Latency: DATA_W cycles from the accept edge to out_valid; one word per DATA_W+2 cycles.
// Backpressure: the result is held in OUT until out_ready; in_ready stays low outside IDLE.
module lfsr_keystream_cipher #(
  parameter int               WIDTH  = 16,
  parameter int               DATA_W = 8,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_seed_load,
  input  logic [WIDTH-1:0]        i_seed_in,
  output logic                    o_seed_zero,
  output logic                    o_seed_err,
  lfsr_keystream_cipher_if.slave  bus
);

  localparam int               CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_lfsr;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  r_ks;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_seed_zero;
  logic               r_seed_err;

  logic               w_ks_bit;
  logic               w_fb;
  logic [WIDTH-1:0]   w_lfsr_step;
  logic [DATA_W-1:0]  w_ks_next;
  logic               w_last_step;
  logic               w_seed_is_zero;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_step;
  logic               w_finish;
  logic               w_seed_apply;
  logic               w_seed_bad;

  // One Fibonacci step: the outgoing MSB is the keystream bit, the tap parity shifts in at the LSB.
  assign w_ks_bit    = r_lfsr[WIDTH-1];
  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], w_fb};

  // Keystream collects MSB first, so the first step's bit ends up in the word's top bit.
  assign w_ks_next   = (r_ks << 1) | DATA_W'(w_ks_bit);
  assign w_last_step = (r_cnt == LAST);

  // A zero seed would lock the register up; it is swapped for SEED and flagged.
  assign w_seed_is_zero = (i_seed_in == '0);

  // in_ready is forced low in the reset cycle whatever the stale state says.
  assign bus.in_ready  = w_in_ready & ~reset;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_out_data;
  assign o_seed_zero   = r_seed_zero;
  assign o_seed_err    = r_seed_err;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; a seed load in IDLE wins over a pending word.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    w_seed_apply = 1'b0;
    w_seed_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = ~i_seed_load;
        if (i_seed_load) begin
          w_seed_apply = 1'b1;
        end else if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_GEN;
        end
      end
      S_GEN: begin
        w_step     = 1'b1;
        w_seed_bad = i_seed_load;
        if (w_last_step) begin
          w_finish    = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_seed_bad = i_seed_load;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // LFSR: reseeded only in IDLE, advanced only in GEN, frozen otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (w_seed_apply) begin
      r_lfsr <= w_seed_is_zero ? SEED : i_seed_in;
    end else if (w_step) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Sticky zero-seed flag reflects only the most recent honoured seed load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seed_zero <= 1'b0;
    end else if (w_seed_apply) begin
      r_seed_zero <= w_seed_is_zero;
    end
  end

  // Single-cycle pulse for every seed load that arrives while a word is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= w_seed_bad;
    end
  end

  // Word capture, step counter and keystream accumulator for the word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_ks   <= '0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
      r_cnt  <= '0;
      r_ks   <= '0;
    end else if (w_step) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_ks   <= w_ks_next;
    end
  end

  // Result register: loaded on the final step and held through OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
    end else if (w_finish) begin
      r_out_data <= r_data ^ w_ks_next;
    end
  end

endmodule
